wptr_sync_r: RTL

Parametrised write-pointer synchronizer for the read clock domain of the asynchronous FIFO. It carries the Gray-coded write pointer across an N-stage flop chain. It also provides:
- the synchronized pointer converted to binary,
- a per-cycle advance count,
- a change strobe,
- a sticky integrity error when the observed advance exceeds FIFO depth.

It sits between the write-pointer logic and the read-side empty/level logic.

---
 rtl/wptr_sync_r.sv | 80 ++++++++
 1 files changed

// File: rtl/wptr_sync_r.sv
// wptr_sync_r: brings the Gray write pointer into the rclk domain.
// Ports: rclk/rrst_n, wptr in, err_clr in;
//        rq_wptr, rq_wbin, rq_delta, rq_upd and gray_err out.
module wptr_sync_r #(
  parameter int ADDRSIZE = 6,
  parameter int STAGES   = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] rq_wptr,
  output logic [ADDRSIZE:0] rq_wbin,
  output logic [ADDRSIZE:0] rq_delta,
  output logic              rq_upd,
  output logic              gray_err
);

  localparam logic [ADDRSIZE:0] DEPTH =
    {1'b1, {ADDRSIZE{1'b0}}};

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("wptr_sync_r: STAGES must be 2..4");
  end

  logic [STAGES-1:0][ADDRSIZE:0] sync_q;
  logic [ADDRSIZE:0] bin_next;
  logic [ADDRSIZE:0] delta_next;
  logic              upd_next;
  logic              err_set;

  // Plain flop chain: wptr reaches only the first stage.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= wptr;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq_wptr = sync_q[STAGES-1];

  // Binary bit i is the XOR of Gray bits ADDRSIZE..i.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      bin_next[i] = ^(rq_wptr >> i);
    end
  end

  // Modulo subtraction covers pointer wrap.
  assign delta_next = bin_next - rq_wbin;
  assign upd_next   = (bin_next != rq_wbin);
  assign err_set    = (delta_next > DEPTH);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq_wbin  <= '0;
      rq_delta <= '0;
      rq_upd   <= 1'b0;
    end else begin
      rq_wbin  <= bin_next;
      rq_delta <= delta_next;
      rq_upd   <= upd_next;
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gray_err <= 1'b0;
    end else begin
      gray_err <= err_set | (gray_err & ~err_clr);
    end
  end

endmodule
